// File: rtl/alu_pc_unit.sv
// Single-cycle datapath slice: combinational ALU with register-write decode,
// plus the program counter register and its next-PC adder.
module alu_pc_unit #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  output logic [31:0] result,
  output logic        zero,
  output logic        rw,
  input  logic [31:0] in,
  output logic [31:0] pc,
  input  logic [31:0] extendaddr,
  input  logic        chksignal,
  output logic [31:0] newpc
);

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;

  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;

  localparam logic [31:0] PcStep = 32'(PC_STEP);

  logic [31:0] pc_q;

  always_comb begin
    result = 32'h0;
    rw     = 1'b0;
    unique case (opcode)
      OpRtype: begin
        unique case (funct)
          FnAdd: begin result = in1 + in2; rw = 1'b1; end
          FnSub: begin result = in1 - in2; rw = 1'b1; end
          FnAnd: begin result = in1 & in2; rw = 1'b1; end
          FnOr:  begin result = in1 | in2; rw = 1'b1; end
          default: ;
        endcase
      end
      OpLw:  begin result = in1 + in2; rw = 1'b1; end
      // Store computes its address but never writes the register file.
      OpSw:  result = in1 + in2;
      OpBeq: result = in1 - in2;
      default: ;
    endcase
  end

  assign zero = (result == 32'h0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= PC_RESET;
    end else begin
      pc_q <= in;
    end
  end

  assign pc    = pc_q;
  assign newpc = pc_q + PcStep + (chksignal ? extendaddr : 32'h0);

endmodule

// File: tb/tb_alu_pc_unit.sv
// Scoreboard bench for alu_pc_unit: stimulus queues expected outputs, a
// negedge monitor pops and compares them against the DUT.
module tb_alu_pc_unit;

  logic        clk;
  logic        rst_n;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] in1;
  logic [31:0] in2;
  logic [31:0] result;
  logic        zero;
  logic        rw;
  logic [31:0] din;
  logic [31:0] pc;
  logic [31:0] extendaddr;
  logic        chksignal;
  logic [31:0] newpc;

  logic        feed;
  logic [31:0] in_drv;

  assign din = feed ? newpc : in_drv;

  alu_pc_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .funct      (funct),
    .in1        (in1),
    .in2        (in2),
    .result     (result),
    .zero       (zero),
    .rw         (rw),
    .in         (din),
    .pc         (pc),
    .extendaddr (extendaddr),
    .chksignal  (chksignal),
    .newpc      (newpc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          chk_alu;
    logic [31:0] result;
    logic        zero;
    logic        rw;
    bit          chk_pc;
    logic [31:0] pc;
    bit          chk_newpc;
    logic [31:0] newpc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: outputs are stable mid-cycle, so compare on the falling edge.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      if (e.chk_alu) begin
        check({e.name, ".result"}, result, e.result);
        check({e.name, ".zero"}, {31'h0, zero}, {31'h0, e.zero});
        check({e.name, ".rw"}, {31'h0, rw}, {31'h0, e.rw});
      end
      if (e.chk_pc)    check({e.name, ".pc"}, pc, e.pc);
      if (e.chk_newpc) check({e.name, ".newpc"}, newpc, e.newpc);
    end
  end

  task automatic push_alu(input string name, input logic [31:0] r, input logic z,
                          input logic w);
    exp_t e;
    e = '{name: name, chk_alu: 1'b1, result: r, zero: z, rw: w,
          chk_pc: 1'b0, pc: 32'h0, chk_newpc: 1'b0, newpc: 32'h0};
    q.push_back(e);
  endtask

  task automatic push_pc(input string name, input bit cp, input logic [31:0] p,
                         input logic [31:0] np);
    exp_t e;
    e = '{name: name, chk_alu: 1'b0, result: 32'h0, zero: 1'b0, rw: 1'b0,
          chk_pc: cp, pc: p, chk_newpc: 1'b1, newpc: np};
    q.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        z;
    logic        w;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vecs.push_back('{"add",      6'b000000, 6'b100000, 32'd5,         32'd7,         32'd12,        1'b0, 1'b1});
    vecs.push_back('{"sub_neg",  6'b000000, 6'b100010, 32'd3,         32'd5,         32'hFFFFFFFE,  1'b0, 1'b1});
    vecs.push_back('{"and",      6'b000000, 6'b100100, 32'hFF00F0F0,  32'h0F0F00FF,  32'h0F0000F0,  1'b0, 1'b1});
    vecs.push_back('{"or",       6'b000000, 6'b100101, 32'hFF00F0F0,  32'h0F0F00FF,  32'hFF0FF0FF,  1'b0, 1'b1});
    vecs.push_back('{"lw",       6'b100011, 6'b100010, 32'h100,       32'hFFFFFFFC,  32'h000000FC,  1'b0, 1'b1});
    vecs.push_back('{"sw",       6'b101011, 6'b000000, 32'h100,       32'd8,         32'h00000108,  1'b0, 1'b0});
    vecs.push_back('{"beq_eq",   6'b000100, 6'b000000, 32'h1234,      32'h1234,      32'h0,         1'b1, 1'b0});
    vecs.push_back('{"beq_ne",   6'b000100, 6'b000000, 32'd3,         32'd5,         32'hFFFFFFFE,  1'b0, 1'b0});
    vecs.push_back('{"add_wrap", 6'b000000, 6'b100000, 32'hFFFFFFFF,  32'd1,         32'h0,         1'b1, 1'b1});
    vecs.push_back('{"bad_op",   6'b111111, 6'b100000, 32'd5,         32'd7,         32'h0,         1'b1, 1'b0});
    vecs.push_back('{"bad_fn",   6'b000000, 6'b101010, 32'd5,         32'd7,         32'h0,         1'b1, 1'b0});

    rst_n      = 1'b0;
    opcode     = 6'b000000;
    funct      = 6'b100000;
    in1        = 32'd5;
    in2        = 32'd7;
    extendaddr = 32'h0;
    chksignal  = 1'b0;
    feed       = 1'b0;
    in_drv     = 32'h55;

    // In reset: pc held, ALU and newpc still combinational.
    next_cycle();
    push_pc("reset", 1'b1, 32'h0, 32'h1);
    push_alu("reset_alu", 32'd12, 1'b0, 1'b1);
    next_cycle();

    // Release and chain newpc back into the PC.
    feed  = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_pc($sformatf("seq%0d", i), 1'b1, 32'(i), 32'(i + 1));
      next_cycle();
    end

    feed   = 1'b0;
    in_drv = 32'hFFFFFFFF;
    next_cycle();
    push_pc("pc_wrap", 1'b1, 32'hFFFFFFFF, 32'h0);

    in_drv = 32'd10;
    next_cycle();
    chksignal  = 1'b1;
    extendaddr = 32'hFFFFFFFC;
    push_pc("branch_back", 1'b1, 32'd10, 32'd7);
    next_cycle();
    extendaddr = 32'd5;
    push_pc("branch_fwd", 1'b1, 32'd10, 32'd16);
    next_cycle();
    chksignal = 1'b0;

    foreach (vecs[i]) begin
      opcode = vecs[i].op;
      funct  = vecs[i].fn;
      in1    = vecs[i].a;
      in2    = vecs[i].b;
      push_alu(vecs[i].name, vecs[i].r, vecs[i].z, vecs[i].w);
      next_cycle();
    end

    // Asynchronous reset between edges, then pending input discarded.
    in_drv = 32'd9;
    next_cycle();
    push_pc("pre_reset", 1'b1, 32'd9, 32'd10);
    next_cycle();
    #1;
    rst_n  = 1'b0;
    in_drv = 32'h77;
    push_pc("async_reset", 1'b1, 32'h0, 32'h1);
    next_cycle();
    push_pc("reset_hold", 1'b1, 32'h0, 32'h1);
    next_cycle();
    rst_n = 1'b1;
    push_pc("release", 1'b1, 32'h0, 32'h1);
    next_cycle();
    push_pc("after_release", 1'b1, 32'h77, 32'h78);
    next_cycle();
    next_cycle();

    check("queue_drained", 32'(q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
